// File: rtl/debug_uart_rx.sv
// Debug UART receiver: 8N1, LSB first, oversampled with 3-sample majority voting.
// Delivers bytes through a one-entry valid/ready holding register; flags framing and overrun errors.
module debug_uart_rx #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD_RATE  = 115200,
    parameter int OVERSAMPLE = 16            // must be >= 8 and even
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    input  logic       ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int DIV_RAW = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int S_W     = $clog2(OVERSAMPLE);
    localparam int M       = OVERSAMPLE / 2;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [S_W-1:0]   S_LO     = S_W'(M - 1);
    localparam logic [S_W-1:0]   S_MID    = S_W'(M);
    localparam logic [S_W-1:0]   S_DEC    = S_W'(M + 1);
    localparam logic [S_W-1:0]   S_LAST   = S_W'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } state_t;

    state_t           state_q;
    logic             rx_meta_q;
    logic             rxs_q;
    logic [DIV_W-1:0] div_q;
    logic [S_W-1:0]   s_q;
    logic [2:0]       bit_idx_q;
    logic [7:0]       shreg_q;
    logic [1:0]       samp_q;
    logic             deliver_q;
    logic [7:0]       data_q;
    logic             valid_q;
    logic             fe_q;
    logic             ov_q;

    logic tick_d;
    logic maj_d;
    logic start_d;

    assign tick_d  = (div_q == DIV_LAST);
    assign maj_d   = (samp_q[0] & samp_q[1]) | (samp_q[0] & rxs_q) | (samp_q[1] & rxs_q);
    assign start_d = (state_q == IDLE) && !rxs_q;

    assign data      = data_q;
    assign valid     = valid_q;
    assign frame_err = fe_q;
    assign overrun   = ov_q;
    assign busy      = (state_q != IDLE);

    // Two-flop synchronizer; idles high so reset cannot fake a start bit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rxs_q     <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rxs_q     <= rx_meta_q;
        end
    end

    // Tick divider, restarted on the start edge so samples land mid-bit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q <= '0;
        end else if (start_d || tick_d) begin
            div_q <= '0;
        end else begin
            div_q <= div_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            s_q       <= '0;
            bit_idx_q <= '0;
            shreg_q   <= '0;
            samp_q    <= '0;
            deliver_q <= 1'b0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            fe_q      <= 1'b0;
            ov_q      <= 1'b0;
        end else begin
            fe_q      <= 1'b0;
            ov_q      <= 1'b0;
            deliver_q <= 1'b0;

            // Holding register: a pending byte wins over a simultaneous drain
            if (deliver_q) begin
                if (!valid_q || ready) begin
                    data_q  <= shreg_q;
                    valid_q <= 1'b1;
                end else begin
                    ov_q <= 1'b1;
                end
            end else if (valid_q && ready) begin
                valid_q <= 1'b0;
            end

            if (tick_d && state_q != IDLE) begin
                if (s_q == S_LO)  samp_q[0] <= rxs_q;
                if (s_q == S_MID) samp_q[1] <= rxs_q;
            end

            case (state_q)
                IDLE: begin
                    if (!rxs_q) begin
                        state_q   <= START;
                        s_q       <= '0;
                        bit_idx_q <= '0;
                    end
                end
                START: begin
                    if (tick_d) begin
                        if (s_q == S_DEC && maj_d) begin
                            state_q <= IDLE;
                        end else if (s_q == S_LAST) begin
                            state_q   <= DATA;
                            s_q       <= '0;
                            bit_idx_q <= '0;
                        end else begin
                            s_q <= s_q + 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (tick_d) begin
                        if (s_q == S_DEC) shreg_q[bit_idx_q] <= maj_d;
                        if (s_q == S_LAST) begin
                            s_q <= '0;
                            if (bit_idx_q == 3'd7) state_q <= STOP;
                            else                   bit_idx_q <= bit_idx_q + 3'd1;
                        end else begin
                            s_q <= s_q + 1'b1;
                        end
                    end
                end
                STOP: begin
                    // Decide mid stop bit and re-arm at once to catch back-to-back frames
                    if (tick_d) begin
                        if (s_q == S_DEC) begin
                            if (maj_d) begin
                                deliver_q <= 1'b1;
                                state_q   <= IDLE;
                            end else begin
                                fe_q    <= 1'b1;
                                state_q <= WAIT_IDLE;
                                s_q     <= '0;
                            end
                        end else begin
                            s_q <= s_q + 1'b1;
                        end
                    end
                end
                WAIT_IDLE: begin
                    // Needs a full bit time of continuous idle before re-arming
                    if (tick_d) begin
                        if (!rxs_q)              s_q <= '0;
                        else if (s_q == S_LAST) state_q <= IDLE;
                        else                     s_q <= s_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_debug_uart_rx.sv
// Bench for debug_uart_rx at DIV=1 (16 clks per bit): table vectors, directed corners, random frames.
module tb_debug_uart_rx;

    localparam int BIT = 16;

    logic       clk;
    logic       rst;
    logic       rx;
    logic       ready;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    debug_uart_rx #(
        .CLK_FREQ  (1_843_200),
        .BAUD_RATE (115200),
        .OVERSAMPLE(16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx       (rx),
        .data     (data),
        .valid    (valid),
        .ready    (ready),
        .frame_err(frame_err),
        .overrun  (overrun),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_err    = 0;

    // Monitor: observes at negedge, so valid&ready here is the handshake of the next edge
    logic [7:0] got_q[$];
    int   fe_cnt = 0, ov_cnt = 0, fe_wide = 0, ov_wide = 0, both_err = 0, unstable = 0;
    int   vrise_cyc = 0;
    logic prev_valid = 1'b0, prev_hs = 1'b0, prev_fe = 1'b0, prev_ov = 1'b0;
    logic [7:0] prev_data = 8'h00;

    always @(negedge clk) begin
        if (rst) begin
            prev_valid <= 1'b0;
            prev_hs    <= 1'b0;
            prev_fe    <= 1'b0;
            prev_ov    <= 1'b0;
        end else begin
            if (valid && !prev_valid) vrise_cyc <= cyc;
            if (valid && prev_valid && !prev_hs && data !== prev_data) unstable <= unstable + 1;
            if (frame_err) begin
                fe_cnt <= fe_cnt + 1;
                if (prev_fe) fe_wide <= fe_wide + 1;
            end
            if (overrun) begin
                ov_cnt <= ov_cnt + 1;
                if (prev_ov) ov_wide <= ov_wide + 1;
            end
            if (frame_err && overrun) both_err <= both_err + 1;
            if (valid && ready) got_q.push_back(data);
            prev_valid <= valid;
            prev_hs    <= valid && ready;
            prev_data  <= data;
            prev_fe    <= frame_err;
            prev_ov    <= overrun;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        n_checks++;
        if (act < lo || act > hi) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    // All drivers run at posedge+1
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic rx_bit(input logic v, input int len);
        rx = v;
        idle(len);
    endtask

    task automatic send_frame(input logic [7:0] b, input bit stop_ok);
        rx_bit(1'b0, BIT);
        for (int i = 0; i < 8; i++) rx_bit(b[i], BIT);
        rx_bit(stop_ok, BIT);
        rx = 1'b1;
    endtask

    task automatic pulse_ready();
        ready = 1'b1;
        idle(1);
        ready = 1'b0;
    endtask

    typedef struct {
        logic [7:0] din;
        bit         stop_ok;
        int         exp_bytes;
        logic [7:0] exp_data;
        int         exp_fe;
    } vec_t;

    vec_t vecs[6];

    int         g0, f0, o0, t_start;
    logic [7:0] exp_q[$];
    int         exp_fe;

    initial begin
        vecs[0] = '{din: 8'h00, stop_ok: 1'b1, exp_bytes: 1, exp_data: 8'h00, exp_fe: 0};
        vecs[1] = '{din: 8'hFF, stop_ok: 1'b1, exp_bytes: 1, exp_data: 8'hFF, exp_fe: 0};
        vecs[2] = '{din: 8'hA5, stop_ok: 1'b1, exp_bytes: 1, exp_data: 8'hA5, exp_fe: 0};
        vecs[3] = '{din: 8'h3C, stop_ok: 1'b0, exp_bytes: 0, exp_data: 8'h00, exp_fe: 1};
        vecs[4] = '{din: 8'h81, stop_ok: 1'b1, exp_bytes: 1, exp_data: 8'h81, exp_fe: 0};
        vecs[5] = '{din: 8'h7E, stop_ok: 1'b0, exp_bytes: 0, exp_data: 8'h00, exp_fe: 1};

        rst   = 1'b1;
        rx    = 1'b1;
        ready = 1'b0;
        idle(3);
        check("reset_data", data, 8'h00);
        check("reset_valid", valid, 1'b0);
        check("reset_frame_err", frame_err, 1'b0);
        check("reset_overrun", overrun, 1'b0);
        check("reset_busy", busy, 1'b0);
        rst = 1'b0;
        idle(5);

        // Scenario 1: latency, hold while not ready, drop after handshake
        g0 = got_q.size();
        t_start = cyc;
        send_frame(8'hA5, 1'b1);
        check_range("s1_latency", vrise_cyc - t_start, 150, 162);
        idle(40);
        check("s1_valid_held", valid, 1'b1);
        check("s1_data_held", data, 8'hA5);
        pulse_ready();
        check("s1_valid_fall", valid, 1'b0);
        check("s1_hs_count", got_q.size() - g0, 1);
        if (got_q.size() > g0) check("s1_hs_data", got_q[g0], 8'hA5);
        idle(20);

        // Table vectors with a permanently ready consumer
        ready = 1'b1;
        for (int v = 0; v < 6; v++) begin
            g0 = got_q.size();
            f0 = fe_cnt;
            o0 = ov_cnt;
            send_frame(vecs[v].din, vecs[v].stop_ok);
            idle(30);
            check($sformatf("vec%0d_bytes", v), got_q.size() - g0, vecs[v].exp_bytes);
            if (vecs[v].exp_bytes == 1 && got_q.size() > g0)
                check($sformatf("vec%0d_data", v), got_q[g0], vecs[v].exp_data);
            check($sformatf("vec%0d_fe", v), fe_cnt - f0, vecs[v].exp_fe);
            check($sformatf("vec%0d_ov", v), ov_cnt - o0, 0);
        end

        // Scenario 2: back-to-back frames with a minimal stop bit
        g0 = got_q.size();
        f0 = fe_cnt;
        o0 = ov_cnt;
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        idle(30);
        check("s2_bytes", got_q.size() - g0, 2);
        if (got_q.size() >= g0 + 2) begin
            check("s2_first", got_q[g0], 8'h00);
            check("s2_second", got_q[g0+1], 8'hFF);
        end
        check("s2_fe", fe_cnt - f0, 0);
        check("s2_ov", ov_cnt - o0, 0);

        // Scenario 3: framing error, break and glitch must not re-arm, then recovery
        g0 = got_q.size();
        f0 = fe_cnt;
        send_frame(8'h3C, 1'b0);
        rx_bit(1'b0, 30);
        rx_bit(1'b1, 8);
        rx_bit(1'b0, 8);
        rx_bit(1'b1, 40);
        check("s3_fe", fe_cnt - f0, 1);
        check("s3_no_byte", got_q.size() - g0, 0);
        send_frame(8'h5A, 1'b1);
        idle(30);
        check("s3_recover_count", got_q.size() - g0, 1);
        if (got_q.size() > g0) check("s3_recover_data", got_q[g0], 8'h5A);
        check("s3_fe_total", fe_cnt - f0, 1);

        // Scenario 4: short glitch is a false start
        g0 = got_q.size();
        f0 = fe_cnt;
        t_start = cyc;
        rx_bit(1'b0, 4);
        rx = 1'b1;
        idle(2);
        check("s4_busy_during", busy, 1'b1);
        idle(10);
        check("s4_busy_cleared", busy, 1'b0);
        idle(200);
        check("s4_no_byte", got_q.size() - g0, 0);
        check("s4_no_fe", fe_cnt - f0, 0);
        check("s4_valid", valid, 1'b0);

        // Scenario 5: overrun on the second byte while the first is held
        ready = 1'b0;
        g0 = got_q.size();
        o0 = ov_cnt;
        f0 = fe_cnt;
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        idle(5);
        check("s5_ov", ov_cnt - o0, 1);
        check("s5_valid", valid, 1'b1);
        check("s5_data_kept", data, 8'h11);
        pulse_ready();
        idle(200);
        check("s5_one_byte", got_q.size() - g0, 1);
        if (got_q.size() > g0) check("s5_byte", got_q[g0], 8'h11);
        check("s5_valid_after", valid, 1'b0);
        check("s5_fe", fe_cnt - f0, 0);

        // Scenario 6: asynchronous reset mid-frame with a byte held
        send_frame(8'h99, 1'b1);
        idle(5);
        check("s6_pre_valid", valid, 1'b1);
        rx_bit(1'b0, BIT);
        for (int i = 0; i < 4; i++) rx_bit(1'b0 ^ ((8'h77 >> i) & 1), BIT);
        rx_bit(1'b1, 8);
        #2 rst = 1'b1;
        #1;
        check("s6_rst_valid", valid, 1'b0);
        check("s6_rst_data", data, 8'h00);
        check("s6_rst_busy", busy, 1'b0);
        check("s6_rst_flags", {frame_err, overrun}, 2'b00);
        rx = 1'b1;
        idle(3);
        rst = 1'b0;
        idle(200);
        check("s6_no_partial", valid, 1'b0);
        g0 = got_q.size();
        f0 = fe_cnt;
        o0 = ov_cnt;
        send_frame(8'hC3, 1'b1);
        idle(5);
        check("s6_valid", valid, 1'b1);
        check("s6_data", data, 8'hC3);
        check("s6_flags", (fe_cnt - f0) + (ov_cnt - o0), 0);
        pulse_ready();
        idle(5);
        check("s6_hs", got_q.size() - g0, 1);

        // Random frames against a frame-level model: good frames yield their byte, bad ones one frame_err
        ready = 1'b1;
        g0 = got_q.size();
        f0 = fe_cnt;
        o0 = ov_cnt;
        exp_fe = 0;
        for (int k = 0; k < 25; k++) begin
            logic [7:0] b;
            bit ok;
            b  = 8'($urandom);
            ok = ($urandom_range(0, 5) != 0);
            send_frame(b, ok);
            if (ok) begin
                exp_q.push_back(b);
                idle($urandom_range(0, 6));
            end else begin
                exp_fe++;
                idle($urandom_range(20, 30));
            end
        end
        idle(40);
        check("rand_count", got_q.size() - g0, exp_q.size());
        for (int k = 0; k < exp_q.size() && g0 + k < got_q.size(); k++)
            check($sformatf("rand_byte%0d", k), got_q[g0+k], exp_q[k]);
        check("rand_fe", fe_cnt - f0, exp_fe);
        check("rand_ov", ov_cnt - o0, 0);

        check("fe_single_cycle", fe_wide, 0);
        check("ov_single_cycle", ov_wide, 0);
        check("fe_ov_exclusive", both_err, 0);
        check("data_stable", unstable, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/debug_uart_rx.md
Name: debug_uart_rx

Overview:
- UART receiver: the host-to-FPGA direction of the debug serial link. Mirrors the existing debug UART transmitter: 8N1, LSB first, same CLK_FREQ/BAUD_RATE parameters, same data/valid/ready byte handshake.
- Oversamples the asynchronous rx pin and validates start and stop bits.
- Presents each byte through a one-entry holding register with valid/ready. Reports framing and overrun errors to the debug command logic downstream.

Parameters:
- CLK_FREQ, 100_000_000: system clock frequency in Hz.
- BAUD_RATE, 115200: serial bit rate.
- OVERSAMPLE, 16: samples per bit. Must be >= 8 and even.

Ports:
- clk, input, 1: system clock, rising edge.
- rst, input, 1: asynchronous, active-high reset.
- rx, input, 1: serial line, asynchronous, idle high.
- data, output, 8: received byte, valid while valid=1.
- valid, output, 1: byte available in the holding register.
- ready, input, 1: consumer accepts the byte when valid & ready.
- frame_err, output, 1: one-cycle pulse; stop bit sampled low.
- overrun, output, 1: one-cycle pulse; a byte was dropped because the holding register was full.
- busy, output, 1: high whenever the FSM is not in IDLE.

Behaviour:
- Reset (async, rst=1): data=0, valid=0, frame_err=0, overrun=0, busy=0. FSM=IDLE. Synchronizer flops=1. All counters=0.
- Synchronizer: 2-FF on rx. All logic uses the synchronized value rxs.
- Tick generator:
  - DIV = CLK_FREQ/(BAUD_RATE*OVERSAMPLE), integer division, minimum 1.
  - One-clk tick every DIV clks.
  - The divider counter clears on the IDLE->START transition, so sampling is phase-aligned to the start edge.
- Sample counter: s = 0..OVERSAMPLE-1, advances per tick. M = OVERSAMPLE/2.
- Bit decision: majority of rxs at s = M-1, M, M+1. Decided at s = M+1.
- FSM:
  - IDLE: when rxs=0, go to START and clear s, the divider and the bit index.
  - START: at s=M+1, if majority=1 it is a false start; return to IDLE, no flags. Otherwise, at s=OVERSAMPLE-1, go to DATA with bit index 0.
  - DATA: at s=M+1, shift the majority into shreg[bit index] (LSB first). At s=OVERSAMPLE-1, increment bit index. After bit 7, go to STOP.
  - STOP: at s=M+1, evaluate the majority.
    - If 1: deliver shreg and go to IDLE immediately, without waiting out the rest of the stop bit, so back-to-back frames are caught.
    - If 0: pulse frame_err, discard the byte, go to WAIT_IDLE.
  - WAIT_IDLE: stay until rxs has been 1 for OVERSAMPLE consecutive ticks (a break or garbage line does not re-arm), then go to IDLE.
- Delivery, on the cycle after the STOP decision:
  - If valid=0, or valid & ready in that same cycle: load data=shreg and set valid=1.
  - If valid=1 and ready=0: keep the old data, pulse overrun for 1 clk, drop the new byte.
- Handshake:
  - valid falls on the clk after valid & ready, unless a delivery occurs in that cycle.
  - data stays stable while valid=1.
  - ready is ignored when valid=0.
- Latency: valid rises 1 clk after the stop-bit decision tick. That is 2 sync clks plus about (9*OVERSAMPLE + M + 1)*DIV clks after the rx falling edge.
- Reset mid-frame aborts the frame. The partial byte is never delivered. The FSM resumes in IDLE, and a low rx at release starts a new frame.
- frame_err and overrun never assert together and are never stretched beyond 1 clk.

Test Plan:
All scenarios use CLK_FREQ=1_843_200, BAUD_RATE=115200, OVERSAMPLE=16, so DIV=1 and one bit = 16 clks.
1. Send 0xA5 (8N1) with ready=0 -> valid rises about 2+154 clks after the start edge. data=0xA5 is held stable until ready=1. valid falls 1 clk after the handshake.
2. Send 0x00 then 0xFF back-to-back (stop bit of exactly 16 clks), ready=1 -> two valid handshakes, data 0x00 then 0xFF. No frame_err, no overrun.
3. Send 0x3C with stop bit driven low, then idle -> frame_err pulses 1 clk, no valid. A following 0x5A is received only after rx has been high for 16 clks.
4. rx low for 4 clks, then high -> no valid, no frame_err. busy returns to 0 by mid-start-bit.
5. Send 0x11 with ready=0, then 0x22 -> overrun pulses 1 clk at the 0x22 decision. data stays 0x11. After ready=1, no second byte appears.
6. Assert rst during data bit 4 of 0x77 -> all outputs 0 immediately. After release, send 0xC3 -> data=0xC3, valid=1, no error flags.
